// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus controller: FSM states, byte-lane enables,
// default I/O window base and the byte extension helper.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRamAcc,
    StIoAcc,
    StResp
  } bus_state_e;

  // RAM byte enables, bit 1 is the high (even-address) byte.
  localparam logic [1:0] BeWord = 2'b11;
  localparam logic [1:0] BeHi   = 2'b10;
  localparam logic [1:0] BeLo   = 2'b01;

  localparam logic [15:0] IoBaseDefault = 16'hFF80;

  // Zero- or sign-extend a byte to a 16-bit word.
  function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sext);
    return {(sext ? {8{b[7]}} : 8'h00), b};
  endfunction

endpackage

// File: rtl/bus_ctrl_byte_lane.sv
// Big-endian lane steering: places write bytes on the right RAM lane and
// extracts/extends read bytes for both the RAM and I/O read paths.
module bus_ctrl_byte_lane
  import bus_ctrl_pkg::*;
(
  input  logic        i_byte,
  input  logic        i_lo,
  input  logic        i_sext,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_rword,
  output logic [1:0]  o_be,
  output logic [15:0] o_wdata,
  output logic [15:0] o_rdata
);

  // Select lane from access size and address parity.
  always_comb begin
    o_be    = BeWord;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    if (i_byte) begin
      if (i_lo) begin
        o_be    = BeLo;
        o_wdata = {8'h00, i_wdata[7:0]};
        o_rdata = extend_byte(i_rword[7:0], i_sext);
      end else begin
        o_be    = BeHi;
        o_wdata = {i_wdata[7:0], 8'h00};
        o_rdata = extend_byte(i_rword[15:8], i_sext);
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// Registered CPU bus controller: decodes one request at a time to word RAM or
// a byte-wide I/O slot, inserts RAM wait states, times out silent devices and
// returns a one-cycle ready/error response.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter logic [15:0] IO_BASE       = IoBaseDefault,
  parameter int unsigned NUM_DEV       = 4,
  parameter int unsigned DEV_SPAN_BITS = 3,
  parameter int unsigned RAM_WAIT      = 1,
  parameter int unsigned IO_TIMEOUT    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic                   cpu_be,
  input  logic                   cpu_sext,
  input  logic [15:0]            cpu_addr,
  input  logic [15:0]            cpu_wdata,
  output logic [15:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [14:0]            ram_addr,
  output logic [15:0]            ram_wdata,
  input  logic [15:0]            ram_rdata,
  output logic [1:0]             ram_be,
  output logic                   ram_we,
  output logic                   ram_re,
  output logic [NUM_DEV-1:0]     io_sel,
  output logic [DEV_SPAN_BITS-1:0] io_addr,
  output logic [7:0]             io_wdata,
  output logic                   io_we,
  output logic                   io_re,
  input  logic [8*NUM_DEV-1:0]   io_rdata,
  input  logic [NUM_DEV-1:0]     io_ack
);

  localparam int unsigned CntMax = (IO_TIMEOUT > RAM_WAIT) ? IO_TIMEOUT : RAM_WAIT;
  localparam int unsigned CntW   = $clog2(CntMax + 2);
  localparam int unsigned IdxW   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  bus_state_e      r_state, w_state_d;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic            r_we;
  logic            r_be;
  logic            r_sext;
  logic            r_err;
  logic [IdxW-1:0] r_idx;
  logic [CntW-1:0] r_cnt;
  logic [15:0]     r_rdata;

  logic [15:0]     w_idx_full;
  logic            w_dec_err;
  logic            w_io_ack;
  logic [7:0]      w_io_byte;
  logic            w_ram_last;
  logic            w_io_timeout;
  logic            w_in_io;
  logic [1:0]      w_lane_be;
  logic [15:0]     w_lane_wdata;
  logic [15:0]     w_lane_rdata;

  assign w_idx_full   = (cpu_addr - IO_BASE) >> DEV_SPAN_BITS;
  // Misaligned word, or I/O window address beyond the last populated slot.
  assign w_dec_err    = (!cpu_be && cpu_addr[0]) ||
                        ((cpu_addr >= IO_BASE) && (w_idx_full >= 16'(NUM_DEV)));
  assign w_io_ack     = io_ack[r_idx];
  assign w_io_byte    = io_rdata[{r_idx, 3'b000} +: 8];
  assign w_ram_last   = (r_cnt == CntW'(RAM_WAIT));
  assign w_io_timeout = (r_cnt == CntW'(IO_TIMEOUT));
  assign w_in_io      = (r_state == StIoAcc);

  // I/O is always byte-wide, so its read path goes through the low lane.
  bus_ctrl_byte_lane u_byte_lane (
    .i_byte  (r_be | w_in_io),
    .i_lo    (r_addr[0] | w_in_io),
    .i_sext  (r_sext),
    .i_wdata (r_wdata),
    .i_rword (w_in_io ? {8'h00, w_io_byte} : ram_rdata),
    .o_be    (w_lane_be),
    .o_wdata (w_lane_wdata),
    .o_rdata (w_lane_rdata)
  );

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (cpu_req) begin
          if (w_dec_err)               w_state_d = StResp;
          else if (cpu_addr < IO_BASE) w_state_d = StRamAcc;
          else                         w_state_d = StIoAcc;
        end
      end
      StRamAcc: if (w_ram_last) w_state_d = StResp;
      StIoAcc:  if (w_io_ack || w_io_timeout) w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // State register, request latch, access counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= 1'b0;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_we    <= cpu_we;
            r_be    <= cpu_be;
            r_sext  <= cpu_sext;
            r_idx   <= w_idx_full[IdxW-1:0];
            r_err   <= w_dec_err;
            r_rdata <= '0;
          end
        end
        StRamAcc: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_ram_last && !r_we) r_rdata <= w_lane_rdata;
        end
        StIoAcc: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_io_ack) begin
            if (!r_we) r_rdata <= w_lane_rdata;
          end else if (w_io_timeout) begin
            r_err <= 1'b1;
          end
        end
        StResp:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign cpu_ready = (r_state == StResp);
  assign cpu_err   = cpu_ready & r_err;
  assign cpu_rdata = cpu_ready ? r_rdata : 16'h0000;

  assign ram_addr  = r_addr[15:1];
  assign ram_be    = (r_state == StRamAcc) ? w_lane_be : 2'b00;
  assign ram_wdata = (r_state == StRamAcc) ? w_lane_wdata : 16'h0000;
  assign ram_we    = (r_state == StRamAcc) && r_we && (r_cnt == '0);
  assign ram_re    = (r_state == StRamAcc) && !r_we;

  assign io_sel    = w_in_io ? (NUM_DEV'(1) << r_idx) : '0;
  assign io_addr   = w_in_io ? r_addr[DEV_SPAN_BITS-1:0] : '0;
  assign io_wdata  = w_in_io ? r_wdata[7:0] : 8'h00;
  assign io_we     = w_in_io && r_we;
  assign io_re     = w_in_io && !r_we;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed self-checking bench for bus_ctrl: RAM word/byte lanes, sign
// extension, I/O read/write, timeout, decode errors, reset and back-to-back.
module tb_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_be = 1'b0, cpu_sext = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [1:0]  ram_be;
  logic        ram_we, ram_re;
  logic [3:0]  io_sel;
  logic [2:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we, io_re;
  logic [31:0] io_rdata = '0;
  logic [3:0]  io_ack = '0;

  int errors = 0;
  int checks = 0;

  // Simple RAM model with a preload port for the bench.
  logic [15:0] mem [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) begin
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
    end
  end

  always #5 clk = ~clk;

  bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_sext  (cpu_sext),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_be    (ram_be),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .io_sel    (io_sel),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic be, input logic sext,
                     input logic [15:0] addr, input logic [15:0] wdata);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_sext = sext;
    cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cpu_ready); end
    checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", cpu_err); end
    checks++; if (cpu_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", cpu_rdata); end
    checks++; if ({ram_we, ram_re, ram_be} !== 4'b0000) begin errors++; $display("FAIL rst_ram got=%b exp=0000", {ram_we, ram_re, ram_be}); end
    checks++; if ({io_sel, io_we, io_re, io_addr, io_wdata} !== 17'h0) begin errors++; $display("FAIL rst_io got=%h exp=0", {io_sel, io_we, io_re, io_addr, io_wdata}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_ram();
    req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234);
    tick(); // cycle 1
    checks++; if (ram_addr !== 15'd8) begin errors++; $display("FAIL ww_addr got=%0d exp=8", ram_addr); end
    checks++; if (ram_be !== 2'b11) begin errors++; $display("FAIL ww_be got=%b exp=11", ram_be); end
    checks++; if (ram_we !== 1'b1 || ram_wdata !== 16'h1234) begin errors++; $display("FAIL ww_we1 got=%b/%h exp=1/1234", ram_we, ram_wdata); end
    tick(); // cycle 2
    checks++; if (ram_we !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL ww_we2 got=%b/%b exp=0/0", ram_we, cpu_ready); end
    tick(); // cycle 3
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 16'h0000) begin errors++; $display("FAIL ww_resp got=%b/%b/%h exp=1/0/0000", cpu_ready, cpu_err, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    tick();
    checks++; if (ram_re !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL wr_re got=%b/%b exp=1/0", ram_re, ram_we); end
    tick();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL wr_early got=%b exp=0", cpu_ready); end
    tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h1234) begin errors++; $display("FAIL wr_data got=%b/%h exp=1/1234", cpu_ready, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_byte_ram();
    preload(15'd8, 16'hCD00);
    req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h77AB);
    tick();
    checks++; if (ram_be !== 2'b01 || ram_wdata !== 16'h00AB) begin errors++; $display("FAIL bw_lane got=%b/%h exp=01/00ab", ram_be, ram_wdata); end
    tick(); tick();
    cpu_req = 1'b0;
    tick();
    checks++; if (mem[8] !== 16'hCDAB) begin errors++; $display("FAIL bw_mem got=%h exp=cdab", mem[8]); end
    req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    checks++; if (ram_be !== 2'b10) begin errors++; $display("FAIL br_be got=%b exp=10", ram_be); end
    tick(); tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h00CD) begin errors++; $display("FAIL br_data got=%b/%h exp=1/00cd", cpu_ready, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_sext();
    preload(15'h20, 16'h9080);
    req(1'b0, 1'b1, 1'b1, 16'h0041, 16'h0000);
    tick(); tick(); tick();
    checks++; if (cpu_rdata !== 16'hFF80) begin errors++; $display("FAIL sext_lo got=%h exp=ff80", cpu_rdata); end
    cpu_req = 1'b0; tick();
    req(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0000);
    tick(); tick(); tick();
    checks++; if (cpu_rdata !== 16'h0080) begin errors++; $display("FAIL zext_lo got=%h exp=0080", cpu_rdata); end
    cpu_req = 1'b0; tick();
    req(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000);
    tick(); tick(); tick();
    checks++; if (cpu_rdata !== 16'hFF90) begin errors++; $display("FAIL sext_hi got=%h exp=ff90", cpu_rdata); end
    cpu_req = 1'b0; tick();
  endtask

  task automatic test_io();
    io_rdata = 32'h3322_5A11; // slot1 = 5A, slot0 = 11
    req(1'b0, 1'b1, 1'b0, 16'hFF8A, 16'h0000);
    tick(); // IO_ACC, counter 0
    checks++; if (io_sel !== 4'b0010 || io_addr !== 3'd2) begin errors++; $display("FAIL io_dec got=%b/%0d exp=0010/2", io_sel, io_addr); end
    checks++; if (io_re !== 1'b1 || io_we !== 1'b0) begin errors++; $display("FAIL io_dir got=%b/%b exp=1/0", io_re, io_we); end
    io_ack = 4'b0001; // foreign ack, must be ignored
    tick(); // counter 1
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL io_foreign got=%b exp=0", cpu_ready); end
    io_ack = 4'b0000;
    tick(); // counter 2
    io_ack = 4'b0010;
    tick(); // cycle 4 = 2+2
    io_ack = 4'b0000;
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 16'h005A) begin errors++; $display("FAIL io_rd got=%b/%b/%h exp=1/0/005a", cpu_ready, cpu_err, cpu_rdata); end
    checks++; if (io_sel !== 4'b0000) begin errors++; $display("FAIL io_release got=%b exp=0000", io_sel); end
    cpu_req = 1'b0; tick();
    // Byte write to device 3, register 5
    req(1'b1, 1'b1, 1'b0, 16'hFF9D, 16'h77C3);
    tick();
    checks++; if (io_sel !== 4'b1000 || io_addr !== 3'd5 || io_wdata !== 8'hC3 || io_we !== 1'b1) begin errors++; $display("FAIL io_wr got=%b/%0d/%h/%b exp=1000/5/c3/1", io_sel, io_addr, io_wdata, io_we); end
    io_ack = 4'b1000;
    tick();
    io_ack = 4'b0000;
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h0000) begin errors++; $display("FAIL io_wr_resp got=%b/%h exp=1/0000", cpu_ready, cpu_rdata); end
    cpu_req = 1'b0; tick();
  endtask

  task automatic test_errors();
    int seen;
    req(1'b0, 1'b1, 1'b0, 16'hFF90, 16'h0000); // device 2, never acks
    seen = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (cpu_ready === 1'b1) begin seen = c; break; end
    end
    checks++; if (seen != 17) begin errors++; $display("FAIL timeout_cycle got=%0d exp=17", seen); end
    checks++; if (cpu_err !== 1'b1 || cpu_rdata !== 16'h0000) begin errors++; $display("FAIL timeout_err got=%b/%h exp=1/0000", cpu_err, cpu_rdata); end
    cpu_req = 1'b0; tick();
    req(1'b0, 1'b1, 1'b0, 16'hFFA0, 16'h0000); // idx 4
    tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || io_sel !== 4'b0000 || io_re !== 1'b0) begin errors++; $display("FAIL bad_idx got=%b/%b/%b/%b exp=1/1/0000/0", cpu_ready, cpu_err, io_sel, io_re); end
    cpu_req = 1'b0; tick();
    req(1'b1, 1'b0, 1'b0, 16'h0003, 16'hBEEF); // misaligned word
    tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || ram_we !== 1'b0 || ram_be !== 2'b00) begin errors++; $display("FAIL misalign got=%b/%b/%b/%b exp=1/1/0/00", cpu_ready, cpu_err, ram_we, ram_be); end
    cpu_req = 1'b0; tick();
    checks++; if (mem[1] === 16'hBEEF) begin errors++; $display("FAIL misalign_mem got=%h exp=not beef", mem[1]); end
  endtask

  task automatic test_reset_mid();
    int rdy;
    req(1'b0, 1'b1, 1'b0, 16'hFF80, 16'h0000);
    tick(); // first IO_ACC cycle
    tick(); // second IO_ACC cycle
    reset = 1'b1;
    tick();
    checks++; if (io_sel !== 4'b0000 || io_re !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_mid got=%b/%b/%b exp=0000/0/0", io_sel, io_re, cpu_ready); end
    reset = 1'b0; cpu_req = 1'b0;
    rdy = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cpu_ready === 1'b1) rdy++;
    end
    checks++; if (rdy != 0) begin errors++; $display("FAIL rst_mid_resp got=%0d exp=0", rdy); end
  endtask

  task automatic test_back_to_back();
    req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    tick(); tick(); tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hCDAB) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/cdab", cpu_ready, cpu_rdata); end
    req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000); // held high straight away
    tick(); // IDLE: RESP did not sample the request
    checks++; if (cpu_ready !== 1'b0 || ram_re !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b/%b exp=0/0", cpu_ready, ram_re); end
    tick(); tick(); tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h9080) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/9080", cpu_ready, cpu_rdata); end
    cpu_req = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_word_ram();
    test_byte_ram();
    test_sext();
    test_io();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
